// File: rtl/multimode_ff_bank.sv
// multimode_ff_bank: WIDTH independent flip-flop cells sharing one clock, one
// synchronous reset and a run-time mode select (SR / JK / D / T).
// Detects the SR illegal input combination per bit and keeps a sticky flag.
//
// Optional feature macro: FF_BANK_ILLCNT_EN adds an 8-bit saturating count of
// enabled SR cycles that had at least one illegal bit.
//
// Ports:
//   CLK      in   rising-edge clock
//   RST      in   synchronous reset, active-high
//   EN       in   cell update enable (0 = all cells hold)
//   MODE     in   2-bit cell function: 00 SR, 01 JK, 10 D, 11 T
//   A        in   WIDTH  S / J / D / T input per bit
//   B        in   WIDTH  R / K input per bit (ignored in D and T)
//   CLR_ERR  in   clears the sticky ILLEGAL flag
//   Q        out  WIDTH  cell state
//   Qbar     out  WIDTH  ~Q, combinational from the state register
//   ILLEGAL  out  sticky illegal-input flag
//   ILL_MASK out  WIDTH  bits that were illegal on the last enabled SR cycle
//   ILL_CNT  out  8      illegal-cycle count (only with FF_BANK_ILLCNT_EN)
module multimode_ff_bank #(
  parameter int unsigned     WIDTH     = 8,
  parameter int unsigned     SR_POLICY = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CLR_ERR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             ILLEGAL,
  output logic [WIDTH-1:0] ILL_MASK
`ifdef FF_BANK_ILLCNT_EN
  ,
  output logic [7:0]       ILL_CNT
`endif
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] sr_base;
  logic [WIDTH-1:0] both;
  logic             ill_any;

  // SR without the illegal case: bits with A=B=1 keep their old value here,
  // so the policy only has to adjust those bits.
  assign both    = A & B;
  assign sr_base = (q_q | (A & ~B)) & ~(~A & B);

  // Illegal detection only counts on enabled SR cycles.
  assign mask_d  = (EN && (mode_e'(MODE) == MODE_SR)) ? both : '0;
  assign ill_any = |mask_d;

  // Cell next-state for the selected mode.
  always_comb begin
    q_d = q_q;
    if (EN) begin
      unique case (mode_e'(MODE))
        MODE_SR: begin
          case (SR_POLICY)
            1:       q_d = sr_base | both;
            2:       q_d = sr_base & ~both;
            3:       q_d = sr_base ^ both;
            default: q_d = sr_base;
          endcase
        end
        MODE_JK: q_d = (q_q & ~B) | (~q_q & A);
        MODE_D:  q_d = A;
        MODE_T:  q_d = q_q ^ A;
        default: q_d = q_q;
      endcase
    end
  end

  // A new illegal event wins over a same-cycle clear.
  always_comb begin
    illegal_d = illegal_q;
    if (ill_any) begin
      illegal_d = 1'b1;
    end else if (CLR_ERR) begin
      illegal_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q       <= RESET_VAL;
      mask_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      mask_q    <= mask_d;
      illegal_q <= illegal_d;
    end
  end

  assign Q        = q_q;
  assign Qbar     = ~q_q;
  assign ILLEGAL  = illegal_q;
  assign ILL_MASK = mask_q;

`ifdef FF_BANK_ILLCNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // One count per illegal cycle, saturating; clear restarts at 1 if the
  // clearing cycle is itself illegal.
  always_comb begin
    cnt_d = cnt_q;
    if (CLR_ERR) begin
      cnt_d = ill_any ? CNT_W'(1) : '0;
    end else if (ill_any && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ILL_CNT = cnt_q;
`endif

endmodule

// File: tb/tb_multimode_ff_bank.sv
// Self-checking bench for multimode_ff_bank: four 8-bit instances (one per
// SR_POLICY) plus a WIDTH=1 instance, all sharing the same stimulus, compared
// against a per-bit behavioural model.
module tb_multimode_ff_bank;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [7:0] a;
  logic [7:0] b;
  logic       clr;

  logic [7:0] q_o    [4];
  logic [7:0] qb_o   [4];
  logic       ill_o  [4];
  logic [7:0] mask_o [4];
`ifdef FF_BANK_ILLCNT_EN
  logic [7:0] cnt_o  [4];
`endif

  logic [0:0] q1_o, qb1_o, mask1_o;
  logic       ill1_o;
`ifdef FF_BANK_ILLCNT_EN
  logic [7:0] cnt1_o;
`endif

  // Reference model state
  logic [7:0] mq [4];
  logic       mill;
  logic [7:0] mmask;
  int         mcnt;

  int n_checks;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar p = 0; p < 4; p++) begin : g_dut
    multimode_ff_bank #(
      .WIDTH(8), .SR_POLICY(p), .RESET_VAL(8'hA5)
    ) u_dut (
      .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .A(a), .B(b),
      .CLR_ERR(clr), .Q(q_o[p]), .Qbar(qb_o[p]), .ILLEGAL(ill_o[p]),
      .ILL_MASK(mask_o[p])
`ifdef FF_BANK_ILLCNT_EN
      , .ILL_CNT(cnt_o[p])
`endif
    );
  end

  multimode_ff_bank #(
    .WIDTH(1), .SR_POLICY(3), .RESET_VAL(1'b1)
  ) u_w1 (
    .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .A(a[0]), .B(b[0]),
    .CLR_ERR(clr), .Q(q1_o), .Qbar(qb1_o), .ILLEGAL(ill1_o),
    .ILL_MASK(mask1_o)
`ifdef FF_BANK_ILLCNT_EN
    , .ILL_CNT(cnt1_o)
`endif
  );

  // Behavioural model: applies the cell truth tables bit by bit.
  task automatic model_update();
    logic any;
    if (rst) begin
      for (int p = 0; p < 4; p++) mq[p] = 8'hA5;
      mill = 1'b0; mmask = 8'h00; mcnt = 0;
      return;
    end
    mmask = 8'h00;
    if (en && mode == 2'd0) mmask = a & b;
    any = (mmask != 8'h00);
    if (en) begin
      for (int p = 0; p < 4; p++) begin
        for (int i = 0; i < 8; i++) begin
          logic ai, bi, qi;
          ai = a[i]; bi = b[i]; qi = mq[p][i];
          case (mode)
            2'd0: begin
              if (ai && !bi) qi = 1'b1;
              else if (!ai && bi) qi = 1'b0;
              else if (ai && bi) begin
                if (p == 1) qi = 1'b1;
                else if (p == 2) qi = 1'b0;
                else if (p == 3) qi = ~qi;
              end
            end
            2'd1: begin
              if (ai && !bi) qi = 1'b1;
              else if (!ai && bi) qi = 1'b0;
              else if (ai && bi) qi = ~qi;
            end
            2'd2: qi = ai;
            default: if (ai) qi = ~qi;
          endcase
          mq[p][i] = qi;
        end
      end
    end
    if (any) mill = 1'b1;
    else if (clr) mill = 1'b0;
    if (clr) mcnt = any ? 1 : 0;
    else if (any && mcnt < 255) mcnt = mcnt + 1;
  endtask

  // Drive one cycle of inputs, clock it, update the model, settle.
  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic [7:0] va, input logic [7:0] vb,
                      input logic c);
    @(negedge clk);
    rst = r; en = e; mode = m; a = va; b = vb; clr = c;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 2'd2, 8'hFF, 8'hFF, 1);
    step(1, 0, 2'd0, 8'h11, 8'h11, 0);
    for (int p = 0; p < 4; p++) begin
      n_checks++;
      if (q_o[p] !== 8'hA5 || qb_o[p] !== 8'h5A || ill_o[p] !== 1'b0 ||
          mask_o[p] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset p%0d: Q=%h Qbar=%h ILL=%b MASK=%h want A5 5A 0 00",
                 p, q_o[p], qb_o[p], ill_o[p], mask_o[p]);
      end
    end
    n_checks++;
    if (q1_o !== 1'b1 || qb1_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_w1: Q=%b Qbar=%b want 1 0", q1_o, qb1_o);
    end
  endtask

  task automatic test_sr();
    logic [7:0] exp_q [4];
    step(0, 1, 2'd0, 8'hFF, 8'h00, 0);
    step(0, 1, 2'd0, 8'h00, 8'h0F, 0);
    step(0, 1, 2'd0, 8'h00, 8'h00, 0);
    for (int p = 0; p < 4; p++) begin
      n_checks++;
      if (q_o[p] !== 8'hF0 || ill_o[p] !== 1'b0) begin
        n_fail++;
        $display("FAIL sr_hold p%0d: Q=%h ILL=%b want F0 0", p, q_o[p], ill_o[p]);
      end
    end
    step(0, 1, 2'd0, 8'h01, 8'h01, 0);
    exp_q[0] = 8'hF0; exp_q[1] = 8'hF1; exp_q[2] = 8'hF0; exp_q[3] = 8'hF1;
    for (int p = 0; p < 4; p++) begin
      n_checks++;
      if (q_o[p] !== exp_q[p] || mask_o[p] !== 8'h01 || ill_o[p] !== 1'b1) begin
        n_fail++;
        $display("FAIL sr_illegal p%0d: Q=%h MASK=%h ILL=%b want %h 01 1",
                 p, q_o[p], mask_o[p], ill_o[p], exp_q[p]);
      end
    end
  endtask

  task automatic test_jk_t();
    step(0, 1, 2'd2, 8'h0F, 8'h00, 0);
    step(0, 1, 2'd1, 8'hFF, 8'hFF, 0);
    for (int p = 0; p < 4; p++) begin
      n_checks++;
      if (q_o[p] !== 8'hF0 || mask_o[p] !== 8'h00) begin
        n_fail++;
        $display("FAIL jk_toggle1 p%0d: Q=%h MASK=%h want F0 00", p, q_o[p], mask_o[p]);
      end
    end
    step(0, 1, 2'd1, 8'hFF, 8'hFF, 0);
    for (int p = 0; p < 4; p++) begin
      n_checks++;
      if (q_o[p] !== 8'h0F) begin
        n_fail++;
        $display("FAIL jk_toggle2 p%0d: Q=%h want 0F", p, q_o[p]);
      end
    end
    step(0, 1, 2'd3, 8'h3C, 8'hFF, 0);
    for (int p = 0; p < 4; p++) begin
      n_checks++;
      if (q_o[p] !== 8'h33 || qb_o[p] !== 8'hCC) begin
        n_fail++;
        $display("FAIL t_mode p%0d: Q=%h Qbar=%h want 33 CC", p, q_o[p], qb_o[p]);
      end
    end
  endtask

  task automatic test_d_enable();
    step(0, 1, 2'd2, 8'h5A, 8'h00, 0);
    for (int p = 0; p < 4; p++) begin
      n_checks++;
      if (q_o[p] !== 8'h5A) begin
        n_fail++;
        $display("FAIL d_mode p%0d: Q=%h want 5A", p, q_o[p]);
      end
    end
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 2'(c), 8'hFF, 8'hFF, 0);
      for (int p = 0; p < 4; p++) begin
        n_checks++;
        if (q_o[p] !== 8'h5A || mask_o[p] !== 8'h00 || ill_o[p] !== mill) begin
          n_fail++;
          $display("FAIL en_hold c%0d p%0d: Q=%h MASK=%h ILL=%b want 5A 00 %b",
                   c, p, q_o[p], mask_o[p], ill_o[p], mill);
        end
      end
    end
  endtask

  task automatic test_sticky();
    step(0, 0, 2'd0, 8'h00, 8'h00, 1);
    n_checks++;
    if (ill_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_clr0: ILL=%b want 0", ill_o[0]);
    end
    step(0, 1, 2'd0, 8'h01, 8'h01, 0);
    step(0, 1, 2'd2, 8'h00, 8'h00, 0);
    n_checks++;
    if (ill_o[1] !== 1'b1 || mask_o[1] !== 8'h00) begin
      n_fail++;
      $display("FAIL sticky_hold: ILL=%b MASK=%h want 1 00", ill_o[1], mask_o[1]);
    end
    step(0, 0, 2'd0, 8'h00, 8'h00, 1);
    n_checks++;
    if (ill_o[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_clr: ILL=%b want 0", ill_o[2]);
    end
    step(0, 1, 2'd0, 8'h80, 8'h80, 1);
    for (int p = 0; p < 4; p++) begin
      n_checks++;
      if (ill_o[p] !== 1'b1 || mask_o[p] !== 8'h80) begin
        n_fail++;
        $display("FAIL sticky_setwins p%0d: ILL=%b MASK=%h want 1 80",
                 p, ill_o[p], mask_o[p]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 7) == 0));
      for (int p = 0; p < 4; p++) begin
        n_checks++;
        if (q_o[p] !== mq[p] || qb_o[p] !== ~mq[p] || ill_o[p] !== mill ||
            mask_o[p] !== mmask) begin
          n_fail++;
          $display("FAIL rand n%0d p%0d: Q=%h Qbar=%h ILL=%b MASK=%h want %h %h %b %h",
                   n, p, q_o[p], qb_o[p], ill_o[p], mask_o[p],
                   mq[p], ~mq[p], mill, mmask);
        end
`ifdef FF_BANK_ILLCNT_EN
        n_checks++;
        if (cnt_o[p] !== 8'(mcnt)) begin
          n_fail++;
          $display("FAIL rand_cnt n%0d p%0d: CNT=%0d want %0d", n, p, cnt_o[p], mcnt);
        end
`endif
      end
      n_checks++;
      if (q1_o !== mq[3][0] || qb1_o === q1_o) begin
        n_fail++;
        $display("FAIL rand_w1 n%0d: Q=%b Qbar=%b want %b %b",
                 n, q1_o, qb1_o, mq[3][0], ~mq[3][0]);
      end
    end
  endtask

`ifdef FF_BANK_ILLCNT_EN
  task automatic test_illcnt();
    step(1, 0, 2'd0, 8'h00, 8'h00, 0);
    for (int n = 0; n < 300; n++) begin
      step(0, 1, 2'd0, 8'($urandom) | 8'h01, 8'($urandom) | 8'h01, 0);
      if (n == 0 || n == 254 || n == 299) begin
        n_checks++;
        if (cnt_o[0] !== 8'(n < 255 ? n + 1 : 255)) begin
          n_fail++;
          $display("FAIL illcnt_run n%0d: CNT=%0d want %0d", n, cnt_o[0],
                   (n < 255 ? n + 1 : 255));
        end
      end
    end
    step(0, 0, 2'd0, 8'h00, 8'h00, 1);
    n_checks++;
    if (cnt_o[1] !== 8'd0) begin
      n_fail++;
      $display("FAIL illcnt_clr: CNT=%0d want 0", cnt_o[1]);
    end
    for (int n = 0; n < 10; n++) step(0, 1, 2'd0, 8'h40, 8'h40, 0);
    step(0, 1, 2'd0, 8'h02, 8'h02, 1);
    n_checks++;
    if (cnt_o[2] !== 8'd1) begin
      n_fail++;
      $display("FAIL illcnt_clr_set: CNT=%0d want 1", cnt_o[2]);
    end
    for (int n = 0; n < 9; n++) step(0, 1, 2'd0, 8'h40, 8'h40, 0);
    n_checks++;
    if (cnt_o[3] !== 8'd10) begin
      n_fail++;
      $display("FAIL illcnt_ten: CNT=%0d want 10", cnt_o[3]);
    end
    step(1, 1, 2'd0, 8'hFF, 8'hFF, 1);
    for (int p = 0; p < 4; p++) begin
      n_checks++;
      if (cnt_o[p] !== 8'd0 || q_o[p] !== 8'hA5 || ill_o[p] !== 1'b0) begin
        n_fail++;
        $display("FAIL illcnt_rst p%0d: CNT=%0d Q=%h ILL=%b want 0 A5 0",
                 p, cnt_o[p], q_o[p], ill_o[p]);
      end
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; en = 1'b0; mode = 2'd0; a = 8'h00; b = 8'h00; clr = 1'b0;
    for (int p = 0; p < 4; p++) mq[p] = 8'hA5;
    mill = 1'b0; mmask = 8'h00; mcnt = 0;
    test_reset();
    test_sr();
    test_jk_t();
    test_d_enable();
    test_sticky();
    test_random();
`ifdef FF_BANK_ILLCNT_EN
    test_illcnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multimode_ff_bank.md
Name: multimode_ff_bank

Overview:
- Parametrised successor to the team's single-bit SR flip-flop.
- WIDTH independent flip-flop cells share one clock, one synchronous reset and one run-time mode select: SR, JK, D or T.
- Adds a configurable policy for the SR illegal input combination, a sticky illegal-input flag, and per-bit complement outputs.
- Used as the general storage element in lab datapaths that previously instantiated discrete SR cells.

Parameters:
- WIDTH, 8: number of flip-flop cells (1..32).
- SR_POLICY, 0: response to S=R=1 in SR mode. 0 = hold, 1 = set-dominant, 2 = reset-dominant, 3 = toggle.
- RESET_VAL, 0: WIDTH-bit value loaded into Q on reset.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous reset, active-high.
- EN  in  1  cell update enable; when 0 all cells hold.
- MODE  in  2  cell function: 00 = SR, 01 = JK, 10 = D, 11 = T.
- A  in  WIDTH  per-bit input 1: S in SR mode, J in JK, D in D, T in T.
- B  in  WIDTH  per-bit input 2: R in SR mode, K in JK; ignored in D and T.
- CLR_ERR  in  1  clears the sticky ILLEGAL flag.
- Q  out  WIDTH  cell state.
- Qbar  out  WIDTH  always ~Q (combinational from the register, no extra latency).
- ILLEGAL  out  1  sticky: set when any bit saw A=B=1 in SR mode with EN=1.
- ILL_MASK  out  WIDTH  registered per-bit mask of the bits that were illegal on the last enabled SR cycle.

Behaviour:
- All state updates on the rising edge of CLK; one-cycle latency from inputs to Q.
- RST=1 (synchronous): Q<=RESET_VAL, ILLEGAL<=0, ILL_MASK<=0. RST overrides EN, MODE and CLR_ERR.
- Reset asserted mid-sequence aborts any pending operation; no state carries over.
- EN=0: Q holds, ILL_MASK<=0, ILLEGAL holds (CLR_ERR still acts).
- EN=1, per bit i, SR mode (a=A[i], b=B[i]):
  - 00: hold. 10: set. 01: clear.
  - 11: apply SR_POLICY (hold / set / clear / ~Q[i]).
- EN=1, per bit i, JK mode:
  - 00: hold. 10: set. 01: clear. 11: toggle.
- EN=1, per bit i, D mode: Q[i]<=A[i].
- EN=1, per bit i, T mode: Q[i]<=Q[i]^A[i].
- Illegal detection:
  - ILL_MASK<=A&B when EN=1 and MODE=00; otherwise ILL_MASK<=0.
  - ILLEGAL<=1 if any bit of that mask is set.
- Simultaneous CLR_ERR and a new illegal event in the same cycle: set wins, ILLEGAL=1.
- MODE may change every cycle. No internal mode state; each edge uses the current MODE.
- WIDTH=1 behaves as a single cell; Qbar is never equal to Q.

Optional Feature:
- Macro: FF_BANK_ILLCNT_EN.
- Defined: adds output ILL_CNT (8 bits).
  - Increments by 1 on each enabled SR cycle with any illegal bit (one count per cycle, not per bit).
  - Saturates at 255. Cleared by RST or CLR_ERR.
  - Same-cycle CLR_ERR and illegal event: ILL_CNT<=1.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: RST=1 for 2 cycles with RESET_VAL=8'hA5 -> Q=8'hA5, Qbar=8'h5A, ILLEGAL=0 after the first edge.
- SR sequence, WIDTH=8, MODE=00, EN=1:
  - A=FF,B=00 -> Q=FF.
  - A=00,B=0F -> Q=F0.
  - A=00,B=00 -> Q holds F0.
  - A=B=01 with SR_POLICY=0 -> Q=F0, ILL_MASK=01, ILLEGAL=1.
  - Repeat with SR_POLICY=1/2/3 -> Q=F1 / F0 / F1.
- JK/T: Q=0F, MODE=01, A=B=FF -> Q=F0 next edge, 0F the edge after. MODE=11, A=3C -> Q=33.
- D and enable: MODE=10, A=5A, EN=1 -> Q=5A. EN=0, A=FF for 3 cycles -> Q stays 5A, ILL_MASK=0.
- Sticky flag: raise ILLEGAL, then CLR_ERR=1 alone -> ILLEGAL=0. CLR_ERR=1 with A=B=80 in SR mode -> ILLEGAL=1.
- With FF_BANK_ILLCNT_EN: 300 consecutive illegal SR cycles -> ILL_CNT=255. CLR_ERR -> 0. RST mid-run (after 10 counts) -> ILL_CNT=0, Q=RESET_VAL.
